// File: rtl/nibble_pkg.sv
// Shared state encoding and mode constants for the sequential nibble adder.
package nibble_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_SUM = 1'b1;

endpackage

// File: rtl/nibble_lane_add.sv
// Combinational NIB-bit + NIB-bit adder producing a NIB+1-bit lane sum.
module nibble_lane_add #(
  parameter int NIB = 4
) (
  input  logic [NIB-1:0] a_i,
  input  logic [NIB-1:0] b_i,
  output logic [NIB:0]   sum_o
);

  assign sum_o = {1'b0, a_i} + {1'b0, b_i};

endmodule

// File: rtl/nibble_seq_adder.sv
// Sequential lane adder: walks latched operands one lane per cycle, returning one lane sum or the total.
// Optional lane_valid/lane_sum stream ports are enabled by defining NIBBLE_LANE_STREAM_EN.
//
// state   | meaning
// IDLE    | ready for operands
// RUN     | one lane per cycle, accumulating
// DONE    | result held until out_ready
module nibble_seq_adder
  import nibble_pkg::*;
#(
  parameter  int LANES = 2,
  parameter  int NIB   = 4,
  localparam int SEL_W = (LANES > 1) ? $clog2(LANES) : 1,
  localparam int OUT_W = NIB + 1 + SEL_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [LANES*NIB-1:0] a,
  input  logic [LANES*NIB-1:0] b,
  input  logic                 mode,
  input  logic [SEL_W-1:0]     sel,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_W-1:0]     result,
`ifdef NIBBLE_LANE_STREAM_EN
  output logic                 lane_valid,
  output logic [NIB:0]         lane_sum,
`endif
  output logic                 err
);

  localparam logic [SEL_W-1:0] LAST_LANE = SEL_W'(LANES - 1);
  localparam logic [SEL_W:0]   LANES_C   = (SEL_W + 1)'(LANES);

  state_e                 state_q, state_d;
  logic [LANES*NIB-1:0]   a_q, a_d, b_q, b_d;
  logic                   mode_q, mode_d;
  logic [SEL_W-1:0]       sel_q, sel_d;
  logic [SEL_W-1:0]       lane_q, lane_d;
  logic [OUT_W-1:0]       acc_q, acc_d;
  logic                   err_q, err_d;

  logic [NIB-1:0]         op_a, op_b;
  logic [NIB:0]           sum_w;
  logic                   lane_hit;

  always_comb begin
    op_a = '0;
    op_b = '0;
    for (int i = 0; i < LANES; i++) begin
      if (lane_q == SEL_W'(i)) begin
        op_a = a_q[i*NIB +: NIB];
        op_b = b_q[i*NIB +: NIB];
      end
    end
  end

  nibble_lane_add #(.NIB(NIB)) u_lane_add (
    .a_i   (op_a),
    .b_i   (op_b),
    .sum_o (sum_w)
  );

  assign lane_hit = (mode_q == MODE_SUM) || (lane_q == sel_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      mode_q  <= MODE_SEL;
      sel_q   <= '0;
      lane_q  <= '0;
      acc_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mode_q  <= mode_d;
      sel_q   <= sel_d;
      lane_q  <= lane_d;
      acc_q   <= acc_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    mode_d  = mode_q;
    sel_d   = sel_q;
    lane_d  = lane_q;
    acc_d   = acc_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          mode_d  = mode;
          sel_d   = sel;
          lane_d  = '0;
          acc_d   = '0;
          err_d   = (mode == MODE_SEL) && ({1'b0, sel} >= LANES_C);
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (lane_hit) acc_d = acc_q + OUT_W'(sum_w);
        // Every lane is visited in both modes so latency never depends on mode.
        if (lane_q == LAST_LANE) state_d = ST_DONE;
        else                     lane_d  = lane_q + SEL_W'(1);
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = (out_valid && !err_q) ? acc_q : '0;
  assign err       = out_valid && err_q;

`ifdef NIBBLE_LANE_STREAM_EN
  assign lane_valid = (state_q == ST_RUN);
  assign lane_sum   = lane_valid ? sum_w : '0;
`endif

endmodule

// File: tb/tb_nibble_seq_adder.sv
// Self-checking bench for nibble_seq_adder (LANES=2 and LANES=3 instances) against a lane-sum model.
module tb_nibble_seq_adder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0, in_ready, mode = 1'b0, out_valid, out_ready = 1'b0, err;
  logic [7:0]  a = '0, b = '0;
  logic [0:0]  sel = '0;
  logic [5:0]  result;
  logic        lane_valid;
  logic [4:0]  lane_sum;

  logic        in_valid3 = 1'b0, in_ready3, mode3 = 1'b0, out_valid3, out_ready3 = 1'b0, err3;
  logic [11:0] a3 = '0, b3 = '0;
  logic [1:0]  sel3 = '0;
  logic [6:0]  result3;
  logic        lane_valid3;
  logic [4:0]  lane_sum3;

  int n_vec = 0;
  int n_err = 0;

  nibble_seq_adder #(.LANES(2), .NIB(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .mode(mode), .sel(sel),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
`ifdef NIBBLE_LANE_STREAM_EN
    .lane_valid(lane_valid), .lane_sum(lane_sum),
`endif
    .err(err)
  );

  nibble_seq_adder #(.LANES(3), .NIB(4)) u_dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3),
    .a(a3), .b(b3), .mode(mode3), .sel(sel3),
    .out_valid(out_valid3), .out_ready(out_ready3), .result(result3),
`ifdef NIBBLE_LANE_STREAM_EN
    .lane_valid(lane_valid3), .lane_sum(lane_sum3),
`endif
    .err(err3)
  );

`ifndef NIBBLE_LANE_STREAM_EN
  assign lane_valid  = 1'b0;
  assign lane_sum    = '0;
  assign lane_valid3 = 1'b0;
  assign lane_sum3   = '0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: list of per-lane sums, then pick one lane or add them all.
  function automatic void model(input logic [63:0] ta, input logic [63:0] tb, input int lanes,
                                input logic tm, input int ts, output int res, output bit e);
    int sums[$];
    for (int i = 0; i < lanes; i++)
      sums.push_back(int'((ta >> (4*i)) & 64'hF) + int'((tb >> (4*i)) & 64'hF));
    e = (tm == 1'b0) && (ts >= lanes);
    if (e)        res = 0;
    else if (tm)  res = sums.sum();
    else          res = sums[ts];
  endfunction

  task automatic wait_out(input int lanes, input logic [7:0] ta, input logic [7:0] tb);
    int c = 0;
    while (!out_valid && c < 20) begin
`ifdef NIBBLE_LANE_STREAM_EN
      if (c < lanes) begin
        check("lane_valid", lane_valid, 1);
        check("lane_sum", lane_sum, 32'(ta[c*4 +: 4]) + 32'(tb[c*4 +: 4]));
      end
`endif
      @(posedge clk); #1; c++;
    end
    check("latency", c, lanes);
`ifdef NIBBLE_LANE_STREAM_EN
    check("lane_valid_done", lane_valid, 0);
`endif
  endtask

  task automatic txn2(input logic [7:0] ta, input logic [7:0] tb, input logic tm,
                      input logic [0:0] ts, input int hold);
    int exp_res; bit exp_err; int c = 0;
    model(64'(ta), 64'(tb), 2, tm, int'(ts), exp_res, exp_err);
    in_valid = 1'b1; a = ta; b = tb; mode = tm; sel = ts;
    while (!in_ready && c < 20) begin @(posedge clk); #1; c++; end
    check("accept_wait", 32'(c < 20), 1);
    @(posedge clk); #1;
    in_valid = 1'b0; a = 8'($urandom); b = 8'($urandom); mode = 1'($urandom); sel = 1'($urandom);
    check("in_ready_run", in_ready, 0);
    wait_out(2, ta, tb);
    check("result", result, exp_res);
    check("err", err, 32'(exp_err));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check("hold_valid", out_valid, 1);
      check("hold_result", result, exp_res);
      check("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
    check("ov_drop", out_valid, 0);
    check("idle_ready", in_ready, 1);
  endtask

  task automatic txn3(input logic [11:0] ta, input logic [11:0] tb, input logic tm, input logic [1:0] ts);
    int exp_res; bit exp_err; int c = 0;
    model(64'(ta), 64'(tb), 3, tm, int'(ts), exp_res, exp_err);
    in_valid3 = 1'b1; a3 = ta; b3 = tb; mode3 = tm; sel3 = ts;
    @(posedge clk); #1;
    in_valid3 = 1'b0; a3 = 12'($urandom); b3 = 12'($urandom);
    while (!out_valid3 && c < 20) begin @(posedge clk); #1; c++; end
    check("latency3", c, 3);
    check("result3", result3, exp_res);
    check("err3", err3, 32'(exp_err));
    out_ready3 = 1'b1; @(posedge clk); #1; out_ready3 = 1'b0;
    check("ov_drop3", out_valid3, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    #2;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_err", err, 0);
    check("rst_lane_valid", lane_valid, 0);
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;

    txn2(8'h3C, 8'h5F, 1'b0, 1'b0, 0);
    txn2(8'h3C, 8'h5F, 1'b0, 1'b1, 0);
    txn2(8'h3C, 8'h5F, 1'b1, 1'b0, 0);
    txn2(8'hFF, 8'hFF, 1'b1, 1'b0, 0);
    check("max_sum_value", result, 0);

    // Back-pressure, then in_valid held across the DONE handshake.
    in_valid = 1'b1; a = 8'h3C; b = 8'h5F; mode = 1'b1;
    @(posedge clk); #1;
    a = 8'h12; b = 8'h34; mode = 1'b1;
    wait_out(2, 8'h3C, 8'h5F);
    check("bp_result", result, 32'h23);
    for (int h = 0; h < 5; h++) begin
      @(posedge clk); #1;
      check("bp_valid", out_valid, 1);
      check("bp_stable", result, 32'h23);
      check("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
    check("b2b_ov_drop", out_valid, 0);
    check("b2b_not_taken", in_ready, 1);
    @(posedge clk); #1;
    check("b2b_taken", in_ready, 0);
    in_valid = 1'b0;
    wait_out(2, 8'h12, 8'h34);
    check("b2b_result", result, 32'h0A);
    out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;

    // Reset during first RUN cycle.
    in_valid = 1'b1; a = 8'h3C; b = 8'h5F; mode = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    rst = 1'b1; #1;
    check("rst_run_ov", out_valid, 0);
    check("rst_run_ready", in_ready, 1);
    @(posedge clk); #1; rst = 1'b0;

    // Reset while holding a result in DONE.
    in_valid = 1'b1; a = 8'hA5; b = 8'h5A; mode = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    c = 0;
    while (!out_valid && c < 20) begin @(posedge clk); #1; c++; end
    check("pre_rst_done", out_valid, 1);
    rst = 1'b1; #1;
    check("rst_done_ov", out_valid, 0);
    check("rst_done_result", result, 0);
    @(posedge clk); #1; rst = 1'b0;

    txn2(8'h12, 8'h34, 1'b1, 1'b0, 0);

    for (int i = 0; i < 16; i++)
      txn2(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 3));

    txn3(12'h3C7, 12'h5F1, 1'b0, 2'd3);
    txn3(12'h3C7, 12'h5F1, 1'b0, 2'd0);
    txn3(12'hFFF, 12'hFFF, 1'b1, 2'd3);
    for (int i = 0; i < 6; i++)
      txn3(12'($urandom), 12'($urandom), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/nibble_seq_adder.md
Name: nibble_seq_adder

Overview:
Parametrised, sequential successor to the team's two-lane nibble adder. It latches two LANES*NIB-bit operands and walks them one lane per cycle. Two modes:
- SEL: returns the sum of one selected lane pair.
- SUM: returns the total of all lane-pair sums.
It sits between operand registers and the result bus, with valid/ready handshakes on both sides.

Parameters:
LANES, 2, number of NIB-bit lanes per operand (>=1)
NIB, 4, lane width in bits
SEL_W, (LANES>1 ? $clog2(LANES) : 1), lane-select width (derived, localparam)
OUT_W, NIB+1+SEL_W, result width (derived); holds the worst-case SUM without overflow

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  operands/mode/sel valid
in_ready  out  1  block can accept operands
a  in  LANES*NIB  operand A; lane i = a[i*NIB +: NIB]
b  in  LANES*NIB  operand B, same lane layout
mode  in  1  0 = SEL, 1 = SUM
sel  in  SEL_W  lane index for SEL mode
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
result  out  OUT_W  zero-extended sum
err  out  1  sel >= LANES in SEL mode; qualified by out_valid

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, result=0, err=0, lane counter=0, accumulator=0.
- FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch a, b, mode, sel; clear the accumulator; set lane=0; go to RUN.
  - Latch err = (mode==SEL && sel>=LANES).
- RUN:
  - in_ready=0. In each cycle, lane_sum = a_lane + b_lane, computed at NIB+1 bits.
  - SUM mode: acc += lane_sum on every lane.
  - SEL mode: acc += lane_sum only when lane==sel_q; otherwise acc is unchanged.
  - When lane==LANES-1: go to DONE. Otherwise lane++.
- Latency is fixed and independent of mode: operands accepted at cycle 0, RUN occupies cycles 1..LANES, out_valid=1 from cycle LANES+1.
- DONE:
  - out_valid=1. result=acc, or 0 if err. Both are held stable until out_ready.
  - On out_valid&&out_ready: go to IDLE and drop out_valid the next cycle.
  - No combinational in->out bypass. A new in_valid in the same cycle as the DONE handshake is not accepted; it is accepted in IDLE on the following cycle.
- Width rules:
  - All additions are unsigned and zero-extended to OUT_W.
  - The SUM maximum is LANES*(2^(NIB+1)-2), which is <= 2^OUT_W-1, so no wrap occurs.
- Inputs are sampled only at the IDLE handshake. Changes on a, b, mode or sel during RUN or DONE are ignored.
- Reset asserted mid-RUN or mid-DONE: immediate return to IDLE, the pending result is discarded, and out_valid=0 asynchronously.
- LANES=1: SEL with sel=0 and SUM give identical results. Latency is 2 cycles.

Optional Feature:
NIBBLE_LANE_STREAM_EN
- Defined: adds two outputs:
  - lane_valid (1 bit): pulses high for each RUN cycle.
  - lane_sum (NIB+1 bits): the current lane's sum, for every lane regardless of mode, driven registered-free from the latched operands. Reset value 0 and lane_valid=0.
- Undefined: neither port exists. Core behaviour is identical.

Decomposition:
- Shared package nibble_pkg:
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - mode constants MODE_SEL=1'b0, MODE_SUM=1'b1.
- One natural sub-module: nibble_lane_add, a combinational NIB-bit + NIB-bit -> NIB+1-bit adder, instantiated once and fed by the lane mux.

Test Plan:
- Defaults (LANES=2, NIB=4). a=8'h3C, b=8'h5F, mode=SEL, sel=0 -> after 3 cycles: out_valid=1, result=6'h1B, err=0.
- Same operands, sel=1 -> result=6'h08. Same operands, mode=SUM -> result=6'h23.
- a=8'hFF, b=8'hFF, mode=SUM -> result=6'h3C (max, no wrap). With LANES=3 and sel=3 in SEL mode -> err=1, result=0.
- Back-pressure: out_ready held 0 for 5 cycles in DONE -> result/out_valid stable, in_ready=0. Then out_ready=1 -> IDLE next cycle. in_valid held high -> second operand pair accepted one cycle after the handshake.
- Reset: assert rst during the first RUN cycle -> out_valid=0, in_ready=1 immediately. The next transaction a=8'h12, b=8'h34, SUM -> result=6'h0A.
- With NIBBLE_LANE_STREAM_EN: a=8'h3C, b=8'h5F, mode=SEL, sel=1 -> lane_valid high for cycles 1 and 2, lane_sum=5'h1B then 5'h08. Final result=6'h08.
